sram_tp_bwe_model: RTL and testbench

//  Parametrised behavioural two-port (1W/1R) SRAM with per-bit write mask. Successor to the

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_clear_seq.sv | 54 +++++
 rtl/sram_tp_bwe_model.sv | 134 +++++++++++++
 tb/tb_sram_tp_bwe_model.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the two-port byte/bit-masked SRAM model.
package sram_pkg;

    typedef enum logic [0:0] {CLEAR, READY} sram_init_e;

    localparam int unsigned RD_LAT_MAX = 2;

    // $clog2 that never returns 0, so single-entry arrays still get a 1-bit index.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then parks in READY.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter bit          CLEAR_ON_RST = 1'b1,
    localparam int unsigned CW          = clog2_safe(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [CW-1:0] clr_addr,
    output logic          init_done
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH - 1);
    localparam sram_init_e    RST_STATE = CLEAR_ON_RST ? CLEAR : READY;

    sram_init_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_we    = 1'b0;
        init_done = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY:   init_done = 1'b1;
            default: state_d = RST_STATE;
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/sram_tp_bwe_model.sv
// Behavioural 1W/1R SRAM with per-bit write mask, selectable read latency,
// collision policy, post-reset clear and read-valid strobe.
module sram_tp_bwe_model
    import sram_pkg::*;
#(
    parameter int unsigned DW           = 64,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned AW           = 10,
    parameter int unsigned RD_LAT       = 1,
    parameter bit          BYPASS       = 1'b0,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] AA,
    input  logic [DW-1:0] D,
    input  logic [DW-1:0] BWEB,
    input  logic          WEB,
    input  logic [AW-1:0] AB,
    input  logic          REB,
    input  logic [1:0]    RTSEL,
    input  logic [1:0]    WTSEL,
    input  logic [1:0]    MTSEL,
    output logic [DW-1:0] Q,
    output logic          Q_VLD,
    output logic          INIT_DONE,
    output logic          COLL
);

    localparam int unsigned IW = clog2_safe(DEPTH);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $fatal(1, "sram_tp_bwe_model: RD_LAT must be 1 or 2");
    end
    if (64'(DEPTH) > (64'd1 << AW)) begin : g_bad_depth
        $fatal(1, "sram_tp_bwe_model: DEPTH exceeds 2**AW");
    end

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [IW-1:0] clr_addr;
    logic          ready;

    sram_clear_seq #(
        .DEPTH        (DEPTH),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_clear_seq (
        .clk       (CLK),
        .rst       (RST),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (ready)
    );

    logic          wa_ok, ra_ok;
    logic          wr_req, rd_req, coll_hit;
    logic [IW-1:0] wa_idx, ra_idx;
    logic [DW-1:0] wr_word, rd_word;

    always_comb begin
        wa_ok    = (32'(AA) < DEPTH);
        ra_ok    = (32'(AB) < DEPTH);
        wa_idx   = IW'(AA);
        ra_idx   = IW'(AB);
        wr_req   = ready & ~WEB & wa_ok;
        rd_req   = ready & ~REB;
        coll_hit = wr_req & rd_req & (AA == AB);
        wr_word  = (mem[wa_idx] & BWEB) | (D & ~BWEB);
        if (!ra_ok) begin
            rd_word = '0;
        end else if (BYPASS && coll_hit) begin
            rd_word = wr_word;
        end else begin
            rd_word = mem[ra_idx];
        end
    end

    // Clear writes take priority; user writes are already gated off while clearing.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_req) begin
            mem[wa_idx] <= wr_word;
        end
    end

    logic          fin_vld;
    logic [DW-1:0] fin_dat;

    if (RD_LAT >= 2) begin : g_lat2
        logic          stg_vld_q;
        logic [DW-1:0] stg_dat_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                stg_vld_q <= 1'b0;
                stg_dat_q <= '0;
            end else begin
                stg_vld_q <= rd_req;
                if (rd_req) begin
                    stg_dat_q <= rd_word;
                end
            end
        end

        assign fin_vld = stg_vld_q;
        assign fin_dat = stg_dat_q;
    end else begin : g_lat1
        assign fin_vld = rd_req;
        assign fin_dat = rd_word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q     <= '0;
            Q_VLD <= 1'b0;
            COLL  <= 1'b0;
        end else begin
            Q_VLD <= fin_vld;
            COLL  <= coll_hit;
            if (fin_vld) begin
                Q <= fin_dat;
            end
        end
    end

    assign INIT_DONE = ready;

    // Timing trims exist only for pin compatibility with the hard macro.
    logic unused_trim;
    assign unused_trim = ^{RTSEL, WTSEL, MTSEL};

endmodule

// File: tb/tb_sram_tp_bwe_model.sv
// Randomized self-checking bench: three SRAM configurations share one stimulus stream
// and are compared against an array-based reference model every cycle.
module tb_sram_tp_bwe_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_req = 1'b1;
    logic [9:0]  aa = '0, ab = '0;
    logic [63:0] d = '0, bweb = '1;
    logic        web = 1'b1, reb = 1'b1;
    logic [1:0]  rtsel = '0, wtsel = '0, mtsel = '0;

    logic [63:0] q_w    [3];
    logic        qv_w   [3];
    logic        init_w [3];
    logic        coll_w [3];

    always #5 clk = ~clk;

    sram_tp_bwe_model #(
        .DW(64), .DEPTH(16), .AW(5), .RD_LAT(1), .BYPASS(1'b0), .CLEAR_ON_RST(1'b1)
    ) u0 (
        .CLK(clk), .RST(rst), .AA(aa[4:0]), .D(d), .BWEB(bweb), .WEB(web), .AB(ab[4:0]),
        .REB(reb), .RTSEL(rtsel), .WTSEL(wtsel), .MTSEL(mtsel), .Q(q_w[0]), .Q_VLD(qv_w[0]),
        .INIT_DONE(init_w[0]), .COLL(coll_w[0])
    );

    sram_tp_bwe_model #(
        .DW(64), .DEPTH(16), .AW(4), .RD_LAT(2), .BYPASS(1'b1), .CLEAR_ON_RST(1'b1)
    ) u1 (
        .CLK(clk), .RST(rst), .AA(aa[3:0]), .D(d), .BWEB(bweb), .WEB(web), .AB(ab[3:0]),
        .REB(reb), .RTSEL(rtsel), .WTSEL(wtsel), .MTSEL(mtsel), .Q(q_w[1]), .Q_VLD(qv_w[1]),
        .INIT_DONE(init_w[1]), .COLL(coll_w[1])
    );

    sram_tp_bwe_model #(
        .DW(64), .DEPTH(1000), .AW(10), .RD_LAT(2), .BYPASS(1'b0), .CLEAR_ON_RST(1'b1)
    ) u2 (
        .CLK(clk), .RST(rst), .AA(aa), .D(d), .BWEB(bweb), .WEB(web), .AB(ab),
        .REB(reb), .RTSEL(rtsel), .WTSEL(wtsel), .MTSEL(mtsel), .Q(q_w[2]), .Q_VLD(qv_w[2]),
        .INIT_DONE(init_w[2]), .COLL(coll_w[2])
    );

    function automatic int depth_of(input int u);
        return (u == 2) ? 1000 : 16;
    endfunction
    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction
    function automatic bit byp_of(input int u);
        return (u == 1);
    endfunction
    function automatic int amask_of(input int u);
        return (u == 0) ? 31 : ((u == 1) ? 15 : 1023);
    endfunction

    // Reference state: memory image, edges since reset release, read results keyed by due edge.
    logic [63:0] mdl_mem [3][1024];
    int          edges   [3];
    logic        sch_vld [3][4];
    logic [63:0] sch_dat [3][4];
    logic [63:0] q_exp    [3];
    logic        vld_exp  [3];
    logic        coll_exp [3];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            edges[u]    = 0;
            q_exp[u]    = '0;
            vld_exp[u]  = 1'b0;
            coll_exp[u] = 1'b0;
            for (int s = 0; s < 4; s++) sch_vld[u][s] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int u = 0; u < 3; u++) begin
            int          dp, wa, ra, slot;
            bit          rdy, wok, rok;
            logic [63:0] merged, rd;
            dp  = depth_of(u);
            edges[u]++;
            rdy = edges[u] > dp;
            wa  = int'(aa) & amask_of(u);
            ra  = int'(ab) & amask_of(u);
            wok = wa < dp;
            rok = ra < dp;
            merged = (mdl_mem[u][wa] & bweb) | (d & ~bweb);
            coll_exp[u] = rdy && !web && !reb && wok && (wa == ra);
            if (rdy && !reb) begin
                if (!rok) rd = '0;
                else if (coll_exp[u] && byp_of(u)) rd = merged;
                else rd = mdl_mem[u][ra];
                slot = (edges[u] + lat_of(u) - 1) % 4;
                sch_vld[u][slot] = 1'b1;
                sch_dat[u][slot] = rd;
            end
            if (rdy && !web && wok) mdl_mem[u][wa] = merged;
            if (edges[u] == dp) begin
                for (int i = 0; i < 1024; i++) mdl_mem[u][i] = '0;
            end
            slot = edges[u] % 4;
            vld_exp[u] = sch_vld[u][slot];
            if (sch_vld[u][slot]) begin
                q_exp[u] = sch_dat[u][slot];
                sch_vld[u][slot] = 1'b0;
            end
        end
    endtask

    task automatic check_outs();
        for (int u = 0; u < 3; u++) begin
            check_eq($sformatf("u%0d_q", u), q_w[u], q_exp[u]);
            check_eq($sformatf("u%0d_q_vld", u), 64'(qv_w[u]), 64'(vld_exp[u]));
            check_eq($sformatf("u%0d_coll", u), 64'(coll_w[u]), 64'(coll_exp[u]));
            check_eq($sformatf("u%0d_init_done", u), 64'(init_w[u]),
                     64'(edges[u] >= depth_of(u)));
        end
    endtask

    task automatic cycle(input logic w_n, input logic r_n, input logic [9:0] wa,
                         input logic [9:0] ra, input logic [63:0] wd, input logic [63:0] be);
        @(negedge clk);
        if (rst_req && !rst) model_reset();
        rst   = rst_req;
        web   = w_n;
        reb   = r_n;
        aa    = wa;
        ab    = ra;
        d     = wd;
        bweb  = be;
        rtsel = 2'($urandom);
        wtsel = 2'($urandom);
        mtsel = 2'($urandom);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outs();
    endtask

    function automatic logic [9:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 10'($urandom_range(990, 1023));
        return 10'($urandom_range(0, 31));
    endfunction

    task automatic rnd_cycle();
        logic [9:0]  a, b;
        logic [63:0] be;
        a = rnd_addr();
        b = ($urandom_range(0, 2) == 0) ? a : rnd_addr();
        case ($urandom_range(0, 3))
            0:       be = '0;
            1:       be = '1;
            default: be = {$urandom, $urandom};
        endcase
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
              {$urandom, $urandom}, be);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b1, '0, '0, '0, '1);
    endtask

    initial begin
        model_reset();
        idle(3);
        rst_req = 1'b0;

        // Interrupt the clear at cycle 7, then let a full clear run; traffic meanwhile is ignored.
        repeat (7) rnd_cycle();
        rst_req = 1'b1;
        repeat (2) rnd_cycle();
        rst_req = 1'b0;
        repeat (16) rnd_cycle();

        for (int a = 0; a < 16; a++) cycle(1'b1, 1'b0, '0, 10'(a), '0, '1);
        idle(2);

        cycle(1'b0, 1'b1, 10'd3, '0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
        cycle(1'b1, 1'b0, '0, 10'd3, '0, '1);
        idle(2);
        cycle(1'b0, 1'b1, 10'd3, '0, 64'h1234_5678_9ABC_DEF0, '1);
        cycle(1'b1, 1'b0, '0, 10'd3, '0, '1);
        idle(2);

        cycle(1'b0, 1'b1, 10'd5, '0, 64'hA, '0);
        cycle(1'b0, 1'b0, 10'd5, 10'd5, 64'hB, '0);
        idle(3);

        repeat (1100) rnd_cycle();
        idle(2);

        cycle(1'b0, 1'b0, 10'd1010, 10'd1010, 64'h55, '0);
        for (int a = 995; a < 1024; a++) cycle(1'b1, 1'b0, '0, 10'(a), '0, '1);
        idle(3);

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 10'($urandom_range(0, 15)), '0, '1);
        idle(3);

        repeat (300) rnd_cycle();
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
